// File: rtl/mem_mux.sv
// SRAM-to-DDR read path: issues a burst of row-pair reads, undoes the row[5]
// bank-pair swap, and streams 512-bit beats through a fall-through skid FIFO.
module mem_mux #(
    parameter int SRAM_LAT = 1,
    parameter int DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [18:0]          base_addr,
    input  logic [7:0]           num_beats,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           cs,
    output logic [1:0][18:0]     addr_sram,
    input  logic [1:0][255:0]    rd_data,
    output logic [1:0][255:0]    data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 last
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + SRAM_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [14:0]           row_q, row_d;
    logic [7:0]            total_q, total_d;
    logic [7:0]            issued_q, issued_d;
    logic [7:0]            sent_q, sent_d;
    logic                  cs_q, cs_d;
    logic                  tag_q, tag_d;
    logic [1:0][18:0]      addr_q, addr_d;
    logic                  done_q, done_d;
    logic [SRAM_LAT-1:0]   pipeValid_q, pipeTag_q;

    logic [1:0][255:0]     fifoMem_q [DEPTH];
    logic [PW-1:0]         wrPtr_q, rdPtr_q;
    logic [CW-1:0]         fifoCount_q;
    logic [CW-1:0]         outstanding;
    logic                  push, pushTag, pop;
    logic                  unusedAddr;

    assign unusedAddr = ^base_addr[18:15];

    assign push       = pipeValid_q[SRAM_LAT-1];
    assign pushTag    = pipeTag_q[SRAM_LAT-1];
    assign data_valid = (fifoCount_q != '0);
    assign pop        = data_valid && data_ready;
    assign data_out   = data_valid ? fifoMem_q[rdPtr_q] : '0;
    assign last       = data_valid && (sent_q == (total_q - 8'd1));

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cs        = {cs_q, cs_q};
    assign addr_sram = addr_q;

    // Slots already committed: queued beats plus every read still on its way
    // back. A pop this cycle frees its slot for the next decision.
    always_comb begin
        outstanding = fifoCount_q + CW'(cs_q);
        for (int k = 0; k < SRAM_LAT; k++) begin
            outstanding = outstanding + CW'(pipeValid_q[k]);
        end
        if (pop) begin
            outstanding = outstanding - CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        total_d  = total_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        cs_d     = 1'b0;
        tag_d    = tag_q;
        addr_d   = addr_q;
        done_d   = 1'b0;

        if (pop) begin
            sent_d = sent_q + 8'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_beats == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        total_d  = num_beats;
                        sent_d   = 8'd0;
                        cs_d     = 1'b1;
                        tag_d    = base_addr[5];
                        addr_d   = {{4'd1, base_addr[14:0]}, {4'd0, base_addr[14:0]}};
                        row_d    = base_addr[14:0] + 15'd1;
                        issued_d = 8'd1;
                    end
                end
            end
            READ: begin
                if (issued_q == total_q) begin
                    state_d = DRAIN;
                end else if (outstanding < CW'(DEPTH)) begin
                    cs_d     = 1'b1;
                    tag_d    = row_q[5];
                    addr_d   = {{4'd1, row_q}, {4'd0, row_q}};
                    row_d    = row_q + 15'd1;
                    issued_d = issued_q + 8'd1;
                end
            end
            DRAIN: begin
                if (pop && last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            cs_q        <= 1'b0;
            tag_q       <= 1'b0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            pipeValid_q <= '0;
            pipeTag_q   <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            total_q        <= total_d;
            issued_q       <= issued_d;
            sent_q         <= sent_d;
            cs_q           <= cs_d;
            tag_q          <= tag_d;
            addr_q         <= addr_d;
            done_q         <= done_d;
            pipeValid_q[0] <= cs_q;
            pipeTag_q[0]   <= tag_q;
            for (int k = 1; k < SRAM_LAT; k++) begin
                pipeValid_q[k] <= pipeValid_q[k-1];
                pipeTag_q[k]   <= pipeTag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
            end
            if (push && !pop) begin
                fifoCount_q <= fifoCount_q + CW'(1);
            end else if (pop && !push) begin
                fifoCount_q <= fifoCount_q - CW'(1);
            end
        end
    end

    // Tag 1 means the write path stored this row with its halves exchanged.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= pushTag ? {rd_data[0], rd_data[1]} : rd_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && (fifoCount_q == CW'(DEPTH))));

endmodule

// File: doc/mem_mux.md
# mem_mux

Read-side counterpart of the DDR-to-SRAM write path. The block reads a burst of rows from SRAM bank pair 0/1 and undoes the bank-pair swap that the write path applies on row-address bit 5. It packs each row pair into a 512-bit beat and streams the beats to the DDR write interface under a valid/ready handshake. A small fall-through FIFO absorbs DDR backpressure while SRAM reads are still in flight.

## Interface
- `SRAM_LAT`, default 1: SRAM read latency in cycles, from `cs` asserted to `rd_data` valid. Legal range is 1–2.
- `DEPTH`, default 4: skid FIFO depth in beats. Must be ≥ `SRAM_LAT`+2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request pulse. Sampled only while `busy`=0.
- `base_addr`  in  19  first SRAM row. Only bits [14:0] are used.
- `num_beats`  in  8  number of beats to transfer, 0–255.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the transfer is complete.
- `cs`  out  2  SRAM chip selects for banks 1:0. Both bits always move together.
- `addr_sram`  out  2×19  per-bank address: bank 0 = {4'd0,row}, bank 1 = {4'd1,row}.
- `rd_data`  in  2×256  SRAM read data, valid `SRAM_LAT` cycles after `cs`.
- `data_out`  out  2×256  DDR beat: [0] is the low half, [1] is the high half.
- `data_valid`  out  1  `data_out` holds a beat.
- `data_ready`  in  1  DDR accepts the beat. A transfer occurs when `data_valid` && `data_ready`.
- `last`  out  1  high with the final beat of the burst.

## Operation
- Control has three states: IDLE, READ, DRAIN.
  - IDLE → READ on `start` with `num_beats`≠0. The block latches `row`=`base_addr[14:0]` and `total`=`num_beats`, and clears the `issued`/`sent` counters.
  - IDLE with `start` and `num_beats`=0: `done` pulses in the next cycle. No `cs` is issued and `busy` stays 0.
  - READ: the block issues one read per cycle (`cs`=2'b11, `addr_sram` from `row`) when `issued`<`total` and `fifo_count`+`inflight`<`DEPTH`. Otherwise `cs`=2'b00. Each issue increments `row` mod 2^15 and `issued`.
  - READ → DRAIN when `issued` reaches `total`.
  - DRAIN → IDLE on the handshake of the beat with `last`=1. `done` pulses in the following cycle, and `busy` drops in that same cycle.
- Swap rule: a `row[5]` tag is carried with each in-flight read.
  - Tag=0: `data_out[0]`=`rd_data[0]`, `data_out[1]`=`rd_data[1]`.
  - Tag=1: the halves are exchanged.
  - Swap is evaluated per row, so a burst that crosses a 32-row boundary changes swap mid-burst.
- `inflight` is a `SRAM_LAT`-deep valid shift register. Its output pushes the captured `rd_data` into the FIFO. Push never occurs when the FIFO is full; the credit check guarantees this, and an assertion checks it.
- The FIFO is first-word-fall-through. `data_valid` = FIFO not empty. `data_out` = 0 whenever `data_valid`=0.
- `last` = `data_valid` && (`sent`==`total`−1). `sent` increments on each handshake.
- `start` while `busy`=1 is ignored and has no side effects.
- Pushing and popping in the same cycle is legal, and `fifo_count` does not change.
- `rst` at any point returns the block to IDLE. It flushes the FIFO and in-flight tags and drops returning `rd_data`. The next `start` is accepted in the first cycle after `rst` deasserts.
- Reset values: `busy`=0, `done`=0, `cs`=0, `addr_sram`=0, `data_out`=0, `data_valid`=0, `last`=0.

## Timing
- Cycle numbers below are for `SRAM_LAT`=1.
- `start` is sampled at edge 0.
- In cycle 1: `cs`=2'b11 with row=`base_addr`, and `busy`=1.
- In cycle 2: `rd_data` is valid and is pushed into the FIFO at the edge.
- In cycle 3: `data_valid`=1. First-beat latency is therefore 3 cycles from `start` (2+`SRAM_LAT` in general).
- With `data_ready` held at 1, the block sustains one beat per cycle. The final beat appears in cycle 2+`SRAM_LAT`+N−1, and `done` follows in the next cycle.
- While `data_ready`=0, `data_valid`, `data_out` and `last` must stay stable until the handshake.
- A read issue stalls once `fifo_count`+`inflight` reaches `DEPTH`. Issue resumes in the cycle after a pop frees a slot.
- `cs`/`addr_sram` are registered outputs with no combinational path from `data_ready`.

## Test plan
- **Basic burst:** base_addr=0x00010, N=4, ready=1, SRAM preloaded row r bank b = {r,b}.
  - Beats appear in cycles 3–6 with halves unswapped.
  - `last` is high in cycle 6, `done` in cycle 7, and exactly 4 `cs` pulses occur.
- **Swap crossing:** base_addr=0x0001E, N=4.
  - Rows 0x1E and 0x1F come out unswapped; rows 0x20 and 0x21 come out swapped.
  - `addr_sram[1]` = {4'd1,row} for every row.
- **Backpressure:** N=8, `data_ready` low for cycles 4–10.
  - Outstanding reads never exceed `DEPTH`, beats are not lost or duplicated, order is preserved, and `data_out` stays stable while stalled.
- **Wrap and zero length:** base_addr=0x07FFE, N=3 must read rows 0x7FFE, 0x7FFF, 0x0000. N=0 gives `done` one cycle after `start`, with no `cs` and `busy`=0.
- **Ignored start:** a second `start` issued mid-burst has no effect on the active burst.
- **Reset mid-operation:** with `rst` asserted at cycle 5 of an N=8 burst:
  - Every output is at its reset value in the next cycle.
  - A new burst with N=2 then completes with correct data and no stale beats.
